oam_dma_controller: RTL and testbench

Sequences Game Boy OAM DMA. A CPU store to the DMA register (0xFF46) copies 160 bytes from a source page to OAM (0xFE00–0xFE9F). The block sits between the CPU memory port and the shared memory bus. While a copy runs it owns the bus, blocks CPU accesses outside HRAM and arbitrates the cycles where both want the bus.

---
 rtl/oam_dma_controller.sv | 153 +++++++++++++++
 tb/tb_oam_dma_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: copies LENGTH bytes from a source page into OAM while
// arbitrating the shared bus against CPU traffic (only HRAM and the DMA register stay reachable).
module oam_dma_controller #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hff46,
    parameter logic [15:0] HRAM_LO      = 16'hff80,
    parameter logic [15:0] HRAM_HI      = 16'hfffe,
    parameter int unsigned LENGTH       = 160,
    parameter int unsigned SLOT_CYCLES  = 4
) (
    input  logic        clockgb,
    input  logic        resetn,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_indata,
    input  logic        cpu_load,
    input  logic        cpu_store,
    output logic [7:0]  cpu_outdata,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_indata,
    input  logic [7:0]  bus_outdata,
    output logic        bus_load,
    output logic        bus_store,
    output logic [7:0]  oam_address,
    output logic [7:0]  oam_data,
    output logic        oam_store,
    output logic        dma_active
);

    localparam int unsigned PW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    state_t        state_q;
    logic [PW-1:0] phase_q;
    logic [7:0]    n_q;
    logic [7:0]    src_hi_q;
    logic          dma_active_q;
    logic          issued_q;
    logic [7:0]    issued_idx_q;
    logic          oam_store_q;
    logic [7:0]    oam_address_q;
    logic [7:0]    oam_data_q;
    logic          rd_bus_q;
    logic          rd_loc_q;
    logic [7:0]    rd_data_q;

    logic       cpu_access, is_reg, in_hram, cpu_fwd, cpu_stall, reg_store, dma_issue;
    logic [7:0] page;

    always_comb begin
        cpu_access = cpu_load | cpu_store;
        is_reg     = (cpu_address == DMA_REG_ADDR);
        in_hram    = (cpu_address >= HRAM_LO) && (cpu_address <= HRAM_HI);
        cpu_fwd    = cpu_access && !is_reg && (!dma_active_q || in_hram);
        // Any permitted access, including the register itself, takes the slot from a pending read.
        cpu_stall  = cpu_access && (is_reg || in_hram);
        reg_store  = cpu_store && is_reg;
        dma_issue  = (state_q == XFER) && (phase_q == '0) && !cpu_stall;
        page       = (src_hi_q >= 8'he0) ? (src_hi_q - 8'h20) : src_hi_q;
    end

    always_comb begin
        bus_address = '0;
        bus_indata  = '0;
        bus_load    = 1'b0;
        bus_store   = 1'b0;
        if (cpu_fwd) begin
            bus_address = cpu_address;
            bus_indata  = cpu_indata;
            bus_load    = cpu_load;
            bus_store   = cpu_store;
        end else if (dma_issue) begin
            bus_address = {page, n_q};
            bus_load    = 1'b1;
        end
    end

    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            n_q           <= '0;
            src_hi_q      <= 8'hff;
            dma_active_q  <= 1'b0;
            issued_q      <= 1'b0;
            issued_idx_q  <= '0;
            oam_store_q   <= 1'b0;
            oam_address_q <= '0;
            oam_data_q    <= '0;
            rd_bus_q      <= 1'b0;
            rd_loc_q      <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            // Write-back pipeline runs independently of the FSM so a restart cannot drop an issued byte.
            issued_q     <= dma_issue;
            issued_idx_q <= n_q;
            oam_store_q  <= issued_q;
            if (issued_q) begin
                oam_address_q <= issued_idx_q;
                oam_data_q    <= bus_outdata;
            end
            rd_bus_q  <= cpu_load && cpu_fwd;
            rd_loc_q  <= cpu_load && !cpu_fwd;
            rd_data_q <= is_reg ? src_hi_q : 8'hff;

            if (reg_store) begin
                src_hi_q <= cpu_indata;
                state_q  <= START;
                phase_q  <= '0;
                n_q      <= '0;
            end else begin
                case (state_q)
                    START: begin
                        if (phase_q == PW'(SLOT_CYCLES - 1)) begin
                            state_q      <= XFER;
                            phase_q      <= '0;
                            dma_active_q <= 1'b1;
                        end else begin
                            phase_q <= phase_q + PW'(1);
                        end
                    end
                    XFER: begin
                        if (phase_q == '0) begin
                            if (dma_issue) phase_q <= PW'(1);
                        end else if (phase_q == PW'(2) && n_q == 8'(LENGTH - 1)) begin
                            state_q      <= IDLE;
                            phase_q      <= '0;
                            n_q          <= '0;
                            dma_active_q <= 1'b0;
                        end else if (phase_q == PW'(SLOT_CYCLES - 1)) begin
                            phase_q <= '0;
                            n_q     <= n_q + 8'd1;
                        end else begin
                            phase_q <= phase_q + PW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cpu_outdata = '0;
        if (rd_loc_q)      cpu_outdata = rd_data_q;
        else if (rd_bus_q) cpu_outdata = bus_outdata;
    end

    assign oam_store   = oam_store_q;
    assign oam_address = oam_address_q;
    assign oam_data    = oam_data_q;
    assign dma_active  = dma_active_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: per-cycle expectation tables built from hand-derived
// timelines, with a bus memory that returns the low address byte one cycle after a read.
module tb_oam_dma_controller;

    localparam int NC = 700;

    logic        clockgb = 1'b0;
    logic        resetn  = 1'b0;
    logic [15:0] cpu_address = '0;
    logic [7:0]  cpu_indata  = '0;
    logic        cpu_load    = 1'b0;
    logic        cpu_store   = 1'b0;
    logic [7:0]  cpu_outdata;
    logic [15:0] bus_address;
    logic [7:0]  bus_indata;
    logic [7:0]  bus_outdata = '0;
    logic        bus_load, bus_store;
    logic [7:0]  oam_address, oam_data;
    logic        oam_store, dma_active;

    oam_dma_controller #(
        .DMA_REG_ADDR(16'hff46),
        .HRAM_LO     (16'hff80),
        .HRAM_HI     (16'hfffe),
        .LENGTH      (160),
        .SLOT_CYCLES (4)
    ) dut (
        .clockgb    (clockgb),
        .resetn     (resetn),
        .cpu_address(cpu_address),
        .cpu_indata (cpu_indata),
        .cpu_load   (cpu_load),
        .cpu_store  (cpu_store),
        .cpu_outdata(cpu_outdata),
        .bus_address(bus_address),
        .bus_indata (bus_indata),
        .bus_outdata(bus_outdata),
        .bus_load   (bus_load),
        .bus_store  (bus_store),
        .oam_address(oam_address),
        .oam_data   (oam_data),
        .oam_store  (oam_store),
        .dma_active (dma_active)
    );

    always #5 clockgb = ~clockgb;

    always @(posedge clockgb) bus_outdata <= bus_address[7:0];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [16:0] exp_ld  [NC];
    logic        exp_bs  [NC];
    logic [7:0]  exp_bsd [NC];
    logic        exp_st  [NC];
    logic [7:0]  exp_sti [NC];
    logic        exp_act [NC];
    logic        exp_rdv [NC];
    logic [7:0]  exp_rd  [NC];
    int          stim_op [NC];
    logic [15:0] stim_a  [NC];
    logic [7:0]  stim_d  [NC];

    task automatic clear_tables();
        for (int i = 0; i < NC; i++) begin
            exp_ld[i] = '0; exp_bs[i] = 1'b0; exp_bsd[i] = '0; exp_st[i] = 1'b0;
            exp_sti[i] = '0; exp_act[i] = 1'b0; exp_rdv[i] = 1'b0; exp_rd[i] = '0;
            stim_op[i] = 0; stim_a[i] = '0; stim_d[i] = '0;
        end
    endtask

    task automatic add_xfer(input logic [7:0] page, input int base, input int n_hi, input int stall_n);
        for (int n = 0; n <= n_hi; n++) begin
            int iss;
            iss = base + 4 * n + ((n >= stall_n) ? 1 : 0);
            exp_ld[iss]    = {1'b1, page, 8'(n)};
            exp_st[iss+2]  = 1'b1;
            exp_sti[iss+2] = 8'(n);
        end
    endtask

    task automatic set_act(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_act[i] = 1'b1;
    endtask

    // op: 1 load, 2 store, 3 reset asserted for this cycle
    task automatic stim(input int c, input int op, input logic [15:0] a, input logic [7:0] d);
        stim_op[c] = op; stim_a[c] = a; stim_d[c] = d;
    endtask

    task automatic expect_rd(input int c, input logic [7:0] v);
        exp_rdv[c] = 1'b1; exp_rd[c] = v;
    endtask

    task automatic run(input int last_c);
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clockgb); #1;
            cpu_load    = (stim_op[c] == 1);
            cpu_store   = (stim_op[c] == 2);
            cpu_address = stim_a[c];
            cpu_indata  = stim_d[c];
            resetn      = (stim_op[c] != 3);
            @(negedge clockgb);
            check("bus_load", {15'd0, bus_load}, {15'd0, exp_ld[c][16]});
            if (exp_ld[c][16]) check("bus_address", bus_address, exp_ld[c][15:0]);
            check("bus_store", {15'd0, bus_store}, {15'd0, exp_bs[c]});
            if (exp_bs[c]) check("bus_indata", {8'd0, bus_indata}, {8'd0, exp_bsd[c]});
            check("oam_store", {15'd0, oam_store}, {15'd0, exp_st[c]});
            if (exp_st[c]) begin
                check("oam_address", {8'd0, oam_address}, {8'd0, exp_sti[c]});
                check("oam_data", {8'd0, oam_data}, {8'd0, exp_sti[c]});
            end
            check("dma_active", {15'd0, dma_active}, {15'd0, exp_act[c]});
            if (exp_rdv[c]) check("cpu_outdata", {8'd0, cpu_outdata}, {8'd0, exp_rd[c]});
            if (stim_op[c] == 3) begin
                check("rst_bus_address", bus_address, 16'h0000);
                check("rst_oam_address", {8'd0, oam_address}, 16'h0000);
                check("rst_oam_data", {8'd0, oam_data}, 16'h0000);
                check("rst_cpu_outdata", {8'd0, cpu_outdata}, 16'h0000);
            end
        end
        cpu_load  = 1'b0;
        cpu_store = 1'b0;
        resetn    = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clockgb);
        @(negedge clockgb);
        check("reset_outputs",
              {cpu_outdata, 1'b0, bus_load, bus_store, oam_store, dma_active, 3'd0},
              16'h0000);
        check("reset_oam", {oam_address, oam_data}, 16'h0000);
        check("reset_bus", bus_address, 16'h0000);
        @(posedge clockgb); #1;
        resetn = 1'b1;

        // Idle pass-through and register read-back of the reset value
        clear_tables();
        stim(1, 1, 16'hff46, 8'h00); expect_rd(2, 8'hff);
        stim(3, 1, 16'h1234, 8'h00); exp_ld[3] = {1'b1, 16'h1234}; expect_rd(4, 8'h34);
        stim(5, 2, 16'h8001, 8'h5a); exp_bs[5] = 1'b1; exp_bsd[5] = 8'h5a;
        run(7);

        // Full unstalled transfer from page 0xC1
        clear_tables();
        stim(0, 2, 16'hff46, 8'hc1);
        add_xfer(8'hc1, 5, 159, 1000);
        set_act(5, 643);
        run(646);

        // Folded page 0xE2 -> 0xC2 with blocked and permitted CPU traffic
        clear_tables();
        stim(0, 2, 16'hff46, 8'he2);
        add_xfer(8'hc2, 5, 159, 20);
        set_act(5, 644);
        stim(46, 1, 16'hc000, 8'h00); expect_rd(47, 8'hff);
        stim(50, 2, 16'hfe10, 8'h77);
        stim(85, 1, 16'hff90, 8'h00); exp_ld[85] = {1'b1, 16'hff90}; expect_rd(86, 8'h90);
        stim(650, 1, 16'hff46, 8'h00); expect_rd(651, 8'he2);
        run(652);

        // Restart while byte 50 is in flight, then reset during byte 80 of the new copy
        clear_tables();
        stim(0, 2, 16'hff46, 8'hc5);
        add_xfer(8'hc5, 5, 50, 1000);
        stim(206, 2, 16'hff46, 8'hc3);
        add_xfer(8'hc3, 211, 80, 1000);
        exp_st[533] = 1'b0;
        set_act(5, 531);
        stim(532, 3, 16'h0000, 8'h00);
        stim(533, 3, 16'h0000, 8'h00);
        stim(540, 1, 16'hff46, 8'h00); expect_rd(541, 8'hff);
        run(560);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
